// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C master and the I2C target: byte and address
// widths, where the R/W flag sits in the address byte, and the target FSM
// state encoding.
// No ports (package only).
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_BYTE_W  = 8;
    localparam int I2C_ADDR_W  = 7;
    localparam int I2C_RW_BIT  = 0;
    localparam int I2C_STATE_W = 3;

    // Target FSM states, 3-bit encoding
    typedef enum logic [I2C_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// ----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA lines into the clk domain and derives the
// bus events the target FSM works from.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scl, sda          raw bus lines
//   scl_rise/scl_fall single-cycle edge strobes of synchronized SCL
//   sda_s             synchronized SDA level
//   start_det         SDA fell while SCL stayed high
//   stop_det          SDA rose while SCL stayed high
// ----------------------------------------------------------------------------
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Synchronizer chains plus one delayed copy for edge detection. Everything
    // resets to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SCL must be high in both samples so an SDA change right at an SCL edge
    // is treated as data, not as a bus condition.
    assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// ----------------------------------------------------------------------------
// i2c_target
// Addressable I2C target. ACKs its own 7-bit address, hands written bytes to
// the local side and shifts a local byte out on reads. SDA is open-drain.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   i2c_sc1     bus SCL (input only, the target never stretches the clock)
//   i2c_sda     bus SDA, driven 0 or released to z
//   tx_data     byte returned on a read, latched when tx_req pulses
//   rx_data     last byte written by the master
//   rx_valid    one-cycle pulse when rx_data updates
//   tx_req      one-cycle pulse when tx_data is latched
//   busy        high from address match until STOP / mismatch / NACK
// ----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2c_sc1,
    inout  wire                   i2c_sda,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    output logic                  busy
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_state_t            state_q, state_next;
    logic [2:0]            bit_cnt_q, bit_cnt_next;
    logic                  byte_done_q, byte_done_next;
    logic                  ack_q, ack_next;
    logic                  rw_q, rw_next;
    logic                  sda_low_q, sda_low_next;
    logic [I2C_BYTE_W-1:0] shift_q, shift_next;
    logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_next;
    logic [I2C_BYTE_W-1:0] rx_data_next;
    logic                  rx_valid_next, tx_req_next, busy_next;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (i2c_sc1),
        .sda      (i2c_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    // Open-drain: only ever pull low
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
            rw_q        <= 1'b0;
            sda_low_q   <= 1'b0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_next;
            bit_cnt_q   <= bit_cnt_next;
            byte_done_q <= byte_done_next;
            ack_q       <= ack_next;
            rw_q        <= rw_next;
            sda_low_q   <= sda_low_next;
            shift_q     <= shift_next;
            tx_shift_q  <= tx_shift_next;
            rx_data     <= rx_data_next;
            rx_valid    <= rx_valid_next;
            tx_req      <= tx_req_next;
            busy        <= busy_next;
        end
    end

    // Next-state and output logic. START/STOP are checked first so they win
    // over an SCL edge in the same cycle. byte_done marks that all 8 bits have
    // been shifted, since the 3-bit counter alone reads 0 both before the
    // first bit and after the eighth.
    always_comb begin
        state_next     = state_q;
        bit_cnt_next   = bit_cnt_q;
        byte_done_next = byte_done_q;
        ack_next       = ack_q;
        rw_next        = rw_q;
        sda_low_next   = sda_low_q;
        shift_next     = shift_q;
        tx_shift_next  = tx_shift_q;
        rx_data_next   = rx_data;
        rx_valid_next  = 1'b0;
        tx_req_next    = 1'b0;
        busy_next      = busy;

        if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            ack_next       = 1'b0;
            sda_low_next   = 1'b0;
            shift_next     = '0;
        end else if (stop_det) begin
            state_next     = ST_IDLE;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            ack_next       = 1'b0;
            sda_low_next   = 1'b0;
            shift_next     = '0;
            busy_next      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    busy_next = 1'b0;
                end

                ST_ADDR, ST_WRITE: begin
                    if (scl_rise) begin
                        shift_next   = {shift_q[I2C_BYTE_W-2:0], sda_s};
                        bit_cnt_next = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        bit_cnt_next   = 3'd0;
                        byte_done_next = 1'b0;
                        if (state_q == ST_WRITE) begin
                            rx_data_next  = shift_q;
                            rx_valid_next = 1'b1;
                            sda_low_next  = 1'b1;
                            state_next    = ST_WRITE_ACK;
                        end else if (shift_q[I2C_BYTE_W-1:I2C_BYTE_W-I2C_ADDR_W] == ADDR) begin
                            rw_next      = shift_q[I2C_RW_BIT];
                            sda_low_next = 1'b1;
                            busy_next    = 1'b1;
                            state_next   = ST_ADDR_ACK;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 3'd0;
                        if (rw_q) begin
                            tx_shift_next = tx_data;
                            tx_req_next   = 1'b1;
                            sda_low_next  = ~tx_data[I2C_BYTE_W-1];
                            state_next    = ST_READ;
                        end else begin
                            sda_low_next = 1'b0;
                            state_next   = ST_WRITE;
                        end
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_next = 1'b0;
                        bit_cnt_next = 3'd0;
                        state_next   = ST_WRITE;
                    end
                end

                // Bit 7 is already on the bus; falls 0..6 present bits 6..0,
                // the eighth fall ends the byte and frees SDA for the ACK.
                ST_READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q != 3'd7) begin
                            tx_shift_next = {tx_shift_q[I2C_BYTE_W-2:0], 1'b0};
                            sda_low_next  = ~tx_shift_q[I2C_BYTE_W-2];
                            bit_cnt_next  = bit_cnt_q + 3'd1;
                        end else begin
                            sda_low_next = 1'b0;
                            bit_cnt_next = 3'd0;
                            ack_next     = 1'b0;
                            state_next   = ST_READ_ACK;
                        end
                    end
                end

                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            sda_low_next = 1'b0;
                            busy_next    = 1'b0;
                            bit_cnt_next = 3'd0;
                            state_next   = ST_WAIT_STOP;
                        end else begin
                            ack_next = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_next      = 1'b0;
                        bit_cnt_next  = 3'd0;
                        tx_shift_next = tx_data;
                        tx_req_next   = 1'b1;
                        sda_low_next  = ~tx_data[I2C_BYTE_W-1];
                        state_next    = ST_READ;
                    end
                end

                ST_WAIT_STOP: begin
                    sda_low_next = 1'b0;
                    busy_next    = 1'b0;
                end

                default: begin
                    state_next   = ST_IDLE;
                    sda_low_next = 1'b0;
                    busy_next    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_target
// Directed bench for i2c_target: a bit-banged master drives SCL/SDA with
// 10-clk low and high phases, and expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       master_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    wire        sda_bus;

    int check_count = 0;
    int fail_count  = 0;

    int rx_valid_cnt   = 0;
    int tx_req_cnt     = 0;
    int target_low_cnt = 0;
    int busy_cnt       = 0;

    // Master side of the open-drain bus, with the bus pull-up
    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target #(
        .ADDR       (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i2c_sc1 (scl),
        .i2c_sda (sda_bus),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Bus monitors: pulse-cycle counts and cycles the target pulls SDA low
    always @(posedge clk) begin
        if (rx_valid) rx_valid_cnt <= rx_valid_cnt + 1;
        if (tx_req) tx_req_cnt <= tx_req_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (!master_low && (sda_bus === 1'b0)) target_low_cnt <= target_low_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL clock: set SDA mid-low, raise SCL, sample late in the high phase
    task automatic applyStimulus(input logic bit_val, output logic sampled);
        wait_clks(5);
        master_low = ~bit_val;
        wait_clks(5);
        scl = 1'b1;
        wait_clks(8);
        sampled = sda_bus;
        wait_clks(2);
        scl = 1'b0;
    endtask

    task automatic bus_start();
        wait_clks(5);
        master_low = 1'b0;
        wait_clks(5);
        scl = 1'b1;
        wait_clks(10);
        master_low = 1'b1;
        wait_clks(10);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clks(5);
        master_low = 1'b1;
        wait_clks(5);
        scl = 1'b1;
        wait_clks(10);
        master_low = 1'b0;
        wait_clks(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
        applyStimulus(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                             output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            b[i] = s;
        end
        tx_data = next_tx;
        applyStimulus(~master_ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int         rv0, tr0, tl0, bz0;

        reset      = 1'b1;
        scl        = 1'b1;
        master_low = 1'b0;
        tx_data    = 8'h00;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);

        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_tx_req", tx_req, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_sda", sda_bus, 1'b1);

        // Write: START, 0xA0, 0x3C, STOP
        rv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        checkOutput("wr_addr_ack", ack, 1'b0);
        checkOutput("wr_busy_high", busy, 1'b1);
        write_byte(8'h3C, ack);
        checkOutput("wr_data_ack", ack, 1'b0);
        bus_stop();
        checkOutput("wr_rx_data", rx_data, 8'h3C);
        checkOutput("wr_rx_valid_cnt", rx_valid_cnt - rv0, 1);
        checkOutput("wr_busy_after_stop", busy, 1'b0);

        // Address mismatch: START, 0xA2, 0x55, STOP
        rv0 = rx_valid_cnt;
        tr0 = tx_req_cnt;
        tl0 = target_low_cnt;
        bz0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        checkOutput("mm_addr_nack", ack, 1'b1);
        write_byte(8'h55, ack);
        checkOutput("mm_data_nack", ack, 1'b1);
        bus_stop();
        checkOutput("mm_target_low", target_low_cnt - tl0, 0);
        checkOutput("mm_busy_cycles", busy_cnt - bz0, 0);
        checkOutput("mm_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        checkOutput("mm_tx_req_cnt", tx_req_cnt - tr0, 0);

        // Read: 0xA5 then 0x0F, master ACKs first and NACKs second
        tr0 = tx_req_cnt;
        tx_data = 8'hA5;
        bus_start();
        write_byte(8'hA1, ack);
        checkOutput("rd_addr_ack", ack, 1'b0);
        read_byte(1'b1, 8'h0F, rd);
        checkOutput("rd_byte0", rd, 8'hA5);
        read_byte(1'b0, 8'h0F, rd);
        checkOutput("rd_byte1", rd, 8'h0F);
        wait_clks(6);
        checkOutput("rd_sda_released", sda_bus, 1'b1);
        checkOutput("rd_busy_after_nack", busy, 1'b0);
        bus_stop();
        checkOutput("rd_tx_req_cnt", tx_req_cnt - tr0, 2);
        checkOutput("rd_busy_after_stop", busy, 1'b0);

        // Repeated START: write 0x12, then re-address for a read
        tx_data = 8'h96;
        bus_start();
        write_byte(8'hA0, ack);
        checkOutput("rs_wr_addr_ack", ack, 1'b0);
        write_byte(8'h12, ack);
        checkOutput("rs_wr_data_ack", ack, 1'b0);
        bus_start();
        checkOutput("rs_rx_data", rx_data, 8'h12);
        write_byte(8'hA1, ack);
        checkOutput("rs_rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, 8'h96, rd);
        checkOutput("rs_rd_byte", rd, 8'h96);
        bus_stop();

        // Mid-byte abort: STOP after 4 data bits of a write
        rv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        checkOutput("ab_addr_ack", ack, 1'b0);
        applyStimulus(1'b1, s);
        applyStimulus(1'b0, s);
        applyStimulus(1'b1, s);
        applyStimulus(1'b1, s);
        bus_stop();
        checkOutput("ab_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        checkOutput("ab_busy", busy, 1'b0);
        checkOutput("ab_rx_data_kept", rx_data, 8'h12);

        // Reset during a read of 0x00: target is holding SDA low
        tx_data = 8'h00;
        bus_start();
        write_byte(8'hA1, ack);
        checkOutput("rr_addr_ack", ack, 1'b0);
        applyStimulus(1'b1, s);
        checkOutput("rr_bit7", s, 1'b0);
        applyStimulus(1'b1, s);
        wait_clks(5);
        checkOutput("rr_sda_driven", sda_bus, 1'b0);
        reset = 1'b1;
        wait_clks(1);
        checkOutput("rr_sda_released", sda_bus, 1'b1);
        checkOutput("rr_busy", busy, 1'b0);
        checkOutput("rr_rx_data", rx_data, 8'h00);
        checkOutput("rr_rx_valid", rx_valid, 1'b0);
        checkOutput("rr_tx_req", tx_req, 1'b0);
        reset = 1'b0;
        scl   = 1'b1;
        wait_clks(10);
        checkOutput("rr_idle_sda", sda_bus, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
